sysarray_result_drain: RTL and testbench
========================================

Name: sysarray_result_drain

Overview:
- Output-side counterpart of the sysarray input feed. The feed pushes one packed lane vector (arr1/arr2) per clk while flg steps; this block takes the finished n x n result matrix and streams it out one packed lane vector per beat.
- Captures the full result bus on a start pulse into a local buffer, so the array is free for the next multiply.
- Drains row-wise, or column-wise when transpose is requested, over a valid/ready handshake.
- Lane packing is identical to arr1/arr2, so downstream logic or a loop-back feed can consume the output unchanged.

Parameters:
- N, 31, MSB index of one element; element width is N+1.
- n, 5, matrix dimension; lanes per beat.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse: result bus is valid, capture it.
- transpose  in  1  sampled with start; 0 = drain rows, 1 = drain columns.
- res_flat  in  (N+1)*n*n  result matrix; element (i,j) at bits [(i*n+j)*(N+1) +: N+1].
- out_data  out  (N+1)*n  one beat; lane k at bits [k*(N+1) +: N+1].
- out_idx  out  clog2(n)  row index (transpose=0) or column index (transpose=1) of the current beat.
- out_valid  out  1  beat available.
- out_ready  in  1  downstream accepts the beat.
- out_last  out  1  high with the final beat (out_idx == n-1).
- busy  out  1  buffer holds an undrained matrix.
- done  out  1  one-cycle pulse after the last beat is accepted.

Behaviour:
- Reset values: out_data=0, out_idx=0, out_valid=0, out_last=0, busy=0, done=0, FSM=IDLE. The capture buffer is not reset.
- IDLE state:
  - start=1 → capture res_flat into the buffer, latch transpose, clear the beat counter, go to SEND.
  - On the next cycle: out_valid=1, busy=1, beat 0 presented. Latency from start to first valid is 1 cycle.
- SEND state:
  - Beat b in row mode: lane k = element (b,k). In column mode: lane k = element (k,b). out_idx = b.
  - Handshake occurs in any cycle with out_valid & out_ready.
  - The beat advances only on a handshake. While out_valid=1 and out_ready=0, out_data, out_idx and out_last hold stable.
  - out_ready may be held high, giving one beat per cycle with no bubbles. A full drain then takes n cycles.
- Last beat: handshake with b == n-1 → go to DONE_ST. out_valid drops the following cycle.
- DONE_ST state: lasts one cycle. done=1, busy=0, then return to IDLE. Total start-to-done is n+1 cycles at full throughput.
- start while busy or in DONE_ST: ignored, and the buffer is not overwritten. The producer must wait for busy=0.
- start in the same cycle that done is high: ignored; start is accepted only in IDLE.
- out_ready while out_valid=0: no effect.
- rst mid-drain: takes priority over everything. All outputs return to reset values the next cycle, no done pulse is produced, and the partial drain is discarded.
- Arithmetic: pure data movement. No truncation or sign handling; elements are passed bit-exact.

Decomposition:
- Shared package sysarray_pkg holds:
  - element width W = N+1;
  - lane-slice helper function lane(vec, k);
  - element index function elem(i, j) = i*n + j;
  - FSM state encoding (IDLE, SEND, DONE_ST).
- The feed side uses the same package.
- Sub-module: one, sysarray_lane_mux. It is combinational and selects row b or column b from the buffer given the mode. It is instantiated once and kept separate so it can be unit-checked in isolation.
- Buffer, counter and FSM stay in the top module.

Test Plan:
- Common setup: n=5, N=31, res_flat element (i,j) = 5i+j+1.
- Row drain: start with transpose=0 and out_ready held 1.
  - Expect 5 consecutive beats: beat0 lanes = 1,2,3,4,5; beat4 lanes = 21..25.
  - out_idx = 0..4; out_last only on beat 4; done pulses at cycle start+6; busy high cycles start+1..start+5.
- Column drain: transpose=1.
  - Expect beat0 lanes = 1,6,11,16,21 and beat2 lanes = 3,8,13,18,23.
  - done one cycle after beat 4 is accepted.
- Backpressure: out_ready = 1,0,0,1,0,1... during a row drain.
  - out_data holds stable across every ready=0 cycle; no beat is skipped or duplicated; exactly 5 handshakes occur.
- Start while busy: second start at start+2 with res_flat changed to all 0xFFFFFFFF.
  - Remaining beats still carry the original values; a third start after done captures the new values.
- Reset mid-drain: rst=1 after the 2nd handshake.
  - Next cycle: out_valid=0, busy=0, out_idx=0, no done pulse.
  - A fresh start afterwards drains all 5 rows correctly.
- Back-to-back: start asserted in the same cycle done=1 is ignored; start asserted one cycle later is accepted and first valid follows 1 cycle after it.

Source files
------------

// File: rtl/sysarray_pkg.sv
// Shared types and helpers for the systolic array feed and drain blocks.
// Element width, lane slicing and FSM encoding live here.
package sysarray_pkg;

    localparam int ELEM_MSB = 31;
    localparam int DIM      = 5;
    localparam int W        = ELEM_MSB + 1;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        DONE_ST
    } state_t;

    function automatic int elem(input int i, input int j);
        return i * DIM + j;
    endfunction

    function automatic logic [W-1:0] lane(
        input logic [W*DIM-1:0] vec,
        input int               k
    );
        return vec[k*W +: W];
    endfunction

endpackage

// File: rtl/sysarray_lane_mux.sv
// Selects row b (or column b in transpose mode) of the captured result
// matrix and packs it into one lane vector, lane k at bits [k*W +: W].
module sysarray_lane_mux #(
    parameter int N = 31,
    parameter int n = 5,
    parameter int IW = (n > 1) ? $clog2(n) : 1
) (
    input  logic [(N+1)*n*n-1:0] mat_i,
    input  logic                 col_i,
    input  logic [IW-1:0]        idx_i,
    output logic [(N+1)*n-1:0]   data_o
);
    localparam int W = N + 1;

    always_comb begin
        data_o = '0;
        for (int b = 0; b < n; b++) begin
            if (idx_i == IW'(b)) begin
                for (int k = 0; k < n; k++) begin
                    data_o[k*W +: W] = col_i ? mat_i[(k*n+b)*W +: W]
                                             : mat_i[(b*n+k)*W +: W];
                end
            end
        end
    end

endmodule

// File: rtl/sysarray_result_drain.sv
// Captures the finished n x n result matrix on start and streams it out
// one packed lane vector per valid/ready beat, row- or column-wise.
module sysarray_result_drain
    import sysarray_pkg::*;
#(
    parameter int N = sysarray_pkg::ELEM_MSB,
    parameter int n = sysarray_pkg::DIM,
    parameter int IW = (n > 1) ? $clog2(n) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 transpose,
    input  logic [(N+1)*n*n-1:0] res_flat,
    output logic [(N+1)*n-1:0]   out_data,
    output logic [IW-1:0]        out_idx,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_last,
    output logic                 busy,
    output logic                 done
);
    localparam logic [IW-1:0] LAST = IW'(n - 1);

    state_t                 state_q;
    logic [(N+1)*n*n-1:0]   mat_q;
    logic                   col_q;
    logic [IW-1:0]          idx_q;
    logic                   valid_q;
    logic                   last_q;
    logic                   busy_q;
    logic                   done_q;
    logic [(N+1)*n-1:0]     beat_d;

    sysarray_lane_mux #(
        .N  (N),
        .n  (n),
        .IW (IW)
    ) u_mux (
        .mat_i  (mat_q),
        .col_i  (col_q),
        .idx_i  (idx_q),
        .data_o (beat_d)
    );

    // Buffer is never reset, so gate the beat to keep out_data at 0 when idle.
    assign out_data  = valid_q ? beat_d : '0;
    assign out_idx   = idx_q;
    assign out_valid = valid_q;
    assign out_last  = last_q;
    assign busy      = busy_q;
    assign done      = done_q;

    always_ff @(posedge clk) begin
        if (start && state_q == IDLE && !rst) begin
            mat_q <= res_flat;
            col_q <= transpose;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        idx_q   <= '0;
                        valid_q <= 1'b1;
                        last_q  <= (n == 1);
                        busy_q  <= 1'b1;
                        state_q <= SEND;
                    end
                end
                SEND: begin
                    if (out_ready) begin
                        if (idx_q == LAST) begin
                            idx_q   <= '0;
                            valid_q <= 1'b0;
                            last_q  <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= DONE_ST;
                        end else begin
                            idx_q  <= idx_q + 1'b1;
                            last_q <= (idx_q + 1'b1) == LAST;
                        end
                    end
                end
                DONE_ST: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sysarray_result_drain.sv
// Scoreboard bench for sysarray_result_drain: expected beats are queued at
// each accepted start and a negedge monitor compares every handshake.
module tb_sysarray_result_drain;
    localparam int W  = 32;
    localparam int NN = 5;
    localparam int BW = W * NN;

    localparam logic [BW-1:0] ROW0 = {32'd5, 32'd4, 32'd3, 32'd2, 32'd1};
    localparam logic [BW-1:0] ROW4 = {32'd25, 32'd24, 32'd23, 32'd22, 32'd21};
    localparam logic [BW-1:0] COL0 = {32'd21, 32'd16, 32'd11, 32'd6, 32'd1};
    localparam logic [BW-1:0] COL2 = {32'd23, 32'd18, 32'd13, 32'd8, 32'd3};

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              transpose;
    logic [BW*NN-1:0]  res_flat;
    logic [BW-1:0]     out_data;
    logic [2:0]        out_idx;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;
    logic              busy;
    logic              done;

    typedef struct packed {
        logic [BW-1:0] d;
        logic [2:0]    idx;
        logic          last;
    } beat_t;

    beat_t q[$];
    int    checks = 0;
    int    errors = 0;
    int    hs_cnt = 0;

    logic [BW-1:0] prev_d;
    logic [2:0]    prev_idx;
    logic          prev_last;
    logic          prev_stall = 1'b0;

    sysarray_result_drain dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .transpose (transpose),
        .res_flat  (res_flat),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [BW-1:0] act,
                       input logic [BW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_seq();
        for (int i = 0; i < NN; i++)
            for (int j = 0; j < NN; j++)
                res_flat[(i*NN+j)*W +: W] = 32'(5*i + j + 1);
    endtask

    task automatic push_exp(input bit tr);
        beat_t e;
        for (int b = 0; b < NN; b++) begin
            e.d = '0;
            for (int k = 0; k < NN; k++)
                e.d[k*W +: W] = tr ? res_flat[(k*NN+b)*W +: W]
                                   : res_flat[(b*NN+k)*W +: W];
            e.idx  = 3'(b);
            e.last = (b == NN - 1);
            q.push_back(e);
        end
    endtask

    task automatic wait_done(input string nm, input int max);
        int c;
        c = 0;
        while (!done && c < max) begin
            tick();
            c++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s timeout act=0 exp=1", nm);
        end
    endtask

    always @(negedge clk) begin
        beat_t e;
        if (!rst && prev_stall) begin
            chk("hold_data", out_data, prev_d);
            chk("hold_idx", BW'(out_idx), BW'(prev_idx));
            chk("hold_last", BW'(out_last), BW'(prev_last));
        end
        if (!rst && out_valid && out_ready) begin
            hs_cnt++;
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_empty act=%h exp=none", out_data);
            end else begin
                e = q.pop_front();
                chk("sb_data", out_data, e.d);
                chk("sb_idx", BW'(out_idx), BW'(e.idx));
                chk("sb_last", BW'(out_last), BW'(e.last));
            end
        end
        prev_stall = !rst && out_valid && !out_ready;
        prev_d     = out_data;
        prev_idx   = out_idx;
        prev_last  = out_last;
    end

    initial begin
        int h0;
        bit pat[6];
        pat = '{1, 0, 0, 1, 0, 1};
        rst = 1'b1;
        start = 1'b0;
        transpose = 1'b0;
        out_ready = 1'b0;
        res_flat = '0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_valid", BW'(out_valid), '0);
        chk("rst_busy", BW'(busy), '0);
        chk("rst_done", BW'(done), '0);
        chk("rst_idx", BW'(out_idx), '0);
        chk("rst_data", out_data, '0);
        chk("rst_last", BW'(out_last), '0);

        // Row drain at full throughput
        fill_seq();
        out_ready = 1'b1;
        transpose = 1'b0;
        start = 1'b1;
        push_exp(1'b0);
        tick();
        start = 1'b0;
        chk("row_first_valid", BW'(out_valid), BW'(1));
        chk("row_beat0", out_data, ROW0);
        for (int c = 1; c <= 6; c++) begin
            chk("row_busy", BW'(busy), BW'(c <= 5));
            chk("row_done", BW'(done), BW'(c == 6));
            if (c == 5) begin
                chk("row_beat4", out_data, ROW4);
                chk("row_last4", BW'(out_last), BW'(1));
            end
            if (c < 6) tick();
        end
        tick();
        chk("row_done_once", BW'(done), '0);
        chk("row_valid_off", BW'(out_valid), '0);

        // Column drain
        transpose = 1'b1;
        start = 1'b1;
        push_exp(1'b1);
        tick();
        start = 1'b0;
        transpose = 1'b0;
        chk("col_beat0", out_data, COL0);
        tick();
        tick();
        chk("col_beat2", out_data, COL2);
        tick();
        tick();
        chk("col_last4", BW'(out_last), BW'(1));
        tick();
        chk("col_done", BW'(done), BW'(1));
        tick();

        // Backpressure
        h0 = hs_cnt;
        start = 1'b1;
        push_exp(1'b0);
        tick();
        start = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            out_ready = pat[i % 6];
            tick();
        end
        chk("bp_done", BW'(done), BW'(1));
        chk("bp_handshakes", BW'(hs_cnt - h0), BW'(5));
        out_ready = 1'b1;
        tick();

        // Start while busy is ignored
        start = 1'b1;
        push_exp(1'b0);
        tick();
        start = 1'b0;
        tick();
        res_flat = '1;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("busy_drain", 20);
        tick();
        chk("busy_idle", BW'(busy), '0);
        start = 1'b1;
        push_exp(1'b0);
        tick();
        start = 1'b0;
        chk("new_beat0", out_data, '1);
        wait_done("new_drain", 20);
        tick();

        // Reset mid-drain
        fill_seq();
        h0 = hs_cnt;
        start = 1'b1;
        push_exp(1'b0);
        tick();
        start = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("mid_rst_valid", BW'(out_valid), '0);
        chk("mid_rst_busy", BW'(busy), '0);
        chk("mid_rst_idx", BW'(out_idx), '0);
        chk("mid_rst_done", BW'(done), '0);
        chk("mid_rst_hs", BW'(hs_cnt - h0), BW'(2));
        rst = 1'b0;
        q.delete();
        tick();
        chk("post_rst_done", BW'(done), '0);
        start = 1'b1;
        push_exp(1'b0);
        tick();
        start = 1'b0;
        wait_done("post_rst_drain", 20);
        tick();

        // Back-to-back start around done
        start = 1'b1;
        push_exp(1'b1);
        transpose = 1'b1;
        tick();
        start = 1'b0;
        transpose = 1'b0;
        wait_done("b2b_drain", 20);
        res_flat = '1;
        start = 1'b1;
        tick();
        chk("b2b_ignored", BW'(out_valid), '0);
        push_exp(1'b0);
        tick();
        start = 1'b0;
        chk("b2b_accepted", BW'(out_valid), BW'(1));
        wait_done("b2b_second", 20);
        tick();
        tick();

        chk("sb_leftover", BW'(q.size()), '0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
